mult_sequencer: RTL and testbench
=================================

// Module: mult_sequencer
// PURPOSE
//  Iterative shift-add multiplier with its own sequencing FSM. Offloads MULT from the single-cycle ALU.
//  The control FSM pulses Start in Execute and holds PcSel=PcWait while Stall is high. It captures
//  ProductLo into the accumulator on the cycle Done is high.
//  Supports unsigned and two's-complement operands.
// PARAMETERS
//  WIDTH       8   operand width in bits; Product is 2*WIDTH bits wide.
//  EARLY_EXIT  0   1 = leave RUN once the remaining multiplier is zero. 0 = fixed WIDTH-cycle latency.
// PORTS
//  Clock      in   1        system clock; all state updates on the rising edge.
//  Reset      in   1        synchronous, active-high reset.
//  Start      in   1        request a multiply. Sampled only in IDLE or DONE.
//  Signed     in   1        1 = OpA and OpB are two's complement. Sampled with Start.
//  OpA        in   WIDTH    multiplicand. Sampled with Start.
//  OpB        in   WIDTH    multiplier. Sampled with Start.
//  Busy       out  1        high while in RUN.
//  Stall      out  1        combinational: (state==RUN) | (Start & state!=RUN).
//  Done       out  1        one-cycle pulse; high exactly while in DONE.
//  Product    out  2*WIDTH  registered result; held until the next accepted Start or Reset.
//  ProductLo  out  WIDTH    Product[WIDTH-1:0], for the accumulator write path.
// BEHAVIOUR
//  Reset (edge with Reset=1): state=IDLE, count=0, Busy=0, Done=0, Product=0.
//    Reset overrides Start and aborts any RUN. Outputs are 0 in the following cycle.
//  States (mult_state_t): MS_IDLE, MS_RUN, MS_DONE.
//  IDLE: Start=1 at edge E0 -> accept and go to RUN.
//    Load mcand = zero-extended |OpA| (2*WIDTH bits) and mplr = |OpB|.
//    Load acc=0, count=0, neg = Signed & (OpA[msb]^OpB[msb]).
//    |x| is the two's-complement magnitude when Signed=1, else x unchanged.
//    |-2^(WIDTH-1)| = 2^(WIDTH-1), held unsigned in WIDTH bits.
//  RUN: at each edge, if mplr[0] then acc += mcand.
//    Then mcand <<= 1, mplr >>= 1, count += 1. Arithmetic is modulo 2^(2*WIDTH); no overflow is possible.
//    Last iteration is count==WIDTH-1, or (EARLY_EXIT & next mplr==0).
//    On that edge: go to DONE and write Product = neg ? -(next acc) : next acc.
//  Latency (EARLY_EXIT=0): Start accepted at E0 -> iterations at E1..E_WIDTH -> Done high in cycle E_WIDTH..E_WIDTH+1.
//  DONE: Done=1 for one cycle.
//    Start=1 -> accept exactly as in IDLE (back-to-back) and go to RUN. Otherwise go to IDLE.
//  Start while in RUN: ignored. No queueing, and operands are not resampled.
//  OpA/OpB/Signed changing during RUN: no effect.
//  Product is unchanged in RUN. It is written only on the DONE-entry edge, or cleared by Reset.
//  count width: $clog2(WIDTH)+1 bits. Never exceeds WIDTH-1.
// STRUCTURE
//  opcodes package: add typedef enum logic [1:0] mult_state_t {MS_IDLE, MS_RUN, MS_DONE}.
//  This module holds the FSM, the counter and the sign/abs/negate logic.
//  One sub-module, mult_shift_add: the mcand/mplr/acc registers and one add-shift step.
//    Controls: Load, Step. Flag output: MplrZero.
//  Control FSM integration: treat Stall as a wait condition on MULT.
//    Store to the accumulator when Done=1.
// TESTING
//  1 Reset held 2 cycles, Start=1 meanwhile -> Busy=0, Done=0, Product=0; no RUN entry.
//  2 Signed=0, OpA=13, OpB=11, Start for 1 cycle -> Busy for 8 cycles; Done 8 cycles after the Start edge;
//    Product=16'h008F; ProductLo=8'h8F.
//  3 Signed=1, OpA=8'hFD (-3), OpB=5 -> Product=16'hFFF1.
//    Signed=1, 8'h80*8'h80 -> Product=16'h4000.
//    Signed=0, 8'hFF*8'hFF -> Product=16'hFE01.
//  4 Start held high continuously, OpA=2/OpB=3, then 4/5 during DONE ->
//    Start ignored in RUN; Product=6, then 20 back-to-back with no IDLE cycle.
//  5 Reset asserted at the 4th RUN cycle of 7*9 -> IDLE next cycle, Product=0, no Done pulse.
//  6 EARLY_EXIT=1, OpA=200, OpB=1 -> Done 1 cycle after the Start edge, Product=200.
//    EARLY_EXIT=0 same operands -> Done after 8 cycles.

Source files
------------

// File: rtl/mult_sequencer_pkg.sv
// Shared types for the iterative multiplier.
//   mult_state_t : sequencing FSM states (idle, iterating, result-ready pulse)
package mult_sequencer_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_shift_add.sv
// Datapath of the shift-add multiplier: multiplicand, multiplier and
// accumulator registers plus one add-shift step.
// Ports:
//   Clock, Reset          : clock and synchronous active-high reset
//   Load                  : load LoadMcand/LoadMplr (operand magnitudes) and clear acc
//   Step                  : perform one iteration (conditional add, then shift)
//   LoadMcand, LoadMplr   : WIDTH-bit unsigned magnitudes
//   AccNext               : accumulator value after the current step
//   MplrZero              : multiplier remaining after the current step is zero
module mult_shift_add #(
    parameter int WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Load,
    input  logic                 Step,
    input  logic [WIDTH-1:0]     LoadMcand,
    input  logic [WIDTH-1:0]     LoadMplr,
    output logic [2*WIDTH-1:0]   AccNext,
    output logic                 MplrZero
);

    logic [2*WIDTH-1:0] mcandReg;
    logic [WIDTH-1:0]   mplrReg;
    logic [2*WIDTH-1:0] accReg;

    assign AccNext  = mplrReg[0] ? (accReg + mcandReg) : accReg;
    // Looks one step ahead so the FSM can leave RUN on the same edge
    // that consumes the last set multiplier bit.
    assign MplrZero = (mplrReg[WIDTH-1:1] == '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            mcandReg <= '0;
            mplrReg  <= '0;
            accReg   <= '0;
        end else if (Load) begin
            mcandReg <= {{WIDTH{1'b0}}, LoadMcand};
            mplrReg  <= LoadMplr;
            accReg   <= '0;
        end else if (Step) begin
            accReg   <= AccNext;
            mcandReg <= mcandReg << 1;
            mplrReg  <= mplrReg >> 1;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Iterative shift-add multiplier with its own sequencing FSM.
// Operands are converted to magnitudes on accept, multiplied unsigned over
// WIDTH iterations (or fewer with EARLY_EXIT), and the sign is reapplied
// when the result is written.
// Ports:
//   Clock, Reset   : clock and synchronous active-high reset
//   Start          : request a multiply (sampled in IDLE or DONE)
//   Signed         : operands are two's complement (sampled with Start)
//   OpA, OpB       : multiplicand / multiplier (sampled with Start)
//   Busy           : high while iterating
//   Stall          : pipeline wait request for the control FSM
//   Done           : one-cycle result-ready pulse
//   Product        : registered 2*WIDTH-bit result
//   ProductLo      : low WIDTH bits of Product
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     OpA,
    input  logic [WIDTH-1:0]     OpB,
    output logic                 Busy,
    output logic                 Stall,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product,
    output logic [WIDTH-1:0]     ProductLo
);

    localparam int CW = $clog2(WIDTH) + 1;

    mult_state_t        stateReg, stateNext;
    logic [CW-1:0]      countReg;
    logic               negReg;
    logic [2*WIDTH-1:0] productReg;

    logic               load, step, lastIter, mplrZero;
    logic [WIDTH-1:0]   magA, magB;
    logic [2*WIDTH-1:0] accNext, result;

    // Magnitude in WIDTH bits; the most negative value maps onto itself,
    // which read unsigned is exactly its magnitude.
    assign magA = (Signed & OpA[WIDTH-1]) ? -OpA : OpA;
    assign magB = (Signed & OpB[WIDTH-1]) ? -OpB : OpB;

    assign result   = negReg ? -accNext : accNext;
    assign lastIter = (countReg == CW'(WIDTH - 1)) | (EARLY_EXIT & mplrZero);

    mult_shift_add #(.WIDTH(WIDTH)) u_datapath (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (load),
        .Step      (step),
        .LoadMcand (magA),
        .LoadMplr  (magB),
        .AccNext   (accNext),
        .MplrZero  (mplrZero)
    );

    always_comb begin
        stateNext = stateReg;
        load      = 1'b0;
        step      = 1'b0;
        case (stateReg)
            MS_IDLE: begin
                if (Start) begin
                    load      = 1'b1;
                    stateNext = MS_RUN;
                end
            end
            MS_RUN: begin
                step = 1'b1;
                if (lastIter) begin
                    stateNext = MS_DONE;
                end
            end
            MS_DONE: begin
                if (Start) begin
                    load      = 1'b1;
                    stateNext = MS_RUN;
                end else begin
                    stateNext = MS_IDLE;
                end
            end
            default: stateNext = MS_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateReg   <= MS_IDLE;
            countReg   <= '0;
            negReg     <= 1'b0;
            productReg <= '0;
        end else begin
            stateReg <= stateNext;
            if (load) begin
                countReg <= '0;
                negReg   <= Signed & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
            end else if (step) begin
                if (lastIter) begin
                    // Return to zero so the count never exceeds WIDTH-1.
                    countReg   <= '0;
                    productReg <= result;
                end else begin
                    countReg <= countReg + 1'b1;
                end
            end
        end
    end

    assign Busy      = (stateReg == MS_RUN);
    assign Done      = (stateReg == MS_DONE);
    assign Stall     = (stateReg == MS_RUN) | (Start & (stateReg != MS_RUN));
    assign Product   = productReg;
    assign ProductLo = productReg[WIDTH-1:0];

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;

    // Fixed-latency instance
    logic        start = 1'b0, sgn = 1'b0;
    logic [7:0]  opA = '0, opB = '0;
    logic        busy, stall, done;
    logic [15:0] product;
    logic [7:0]  productLo;

    // Early-exit instance
    logic        startE = 1'b0, sgnE = 1'b0;
    logic [7:0]  opAE = '0, opBE = '0;
    logic        busyE, stallE, doneE;
    logic [15:0] productE;
    logic [7:0]  productLoE;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    mult_sequencer #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut (
        .Clock(Clock), .Reset(Reset), .Start(start), .Signed(sgn),
        .OpA(opA), .OpB(opB), .Busy(busy), .Stall(stall), .Done(done),
        .Product(product), .ProductLo(productLo)
    );

    mult_sequencer #(.WIDTH(8), .EARLY_EXIT(1'b1)) dutE (
        .Clock(Clock), .Reset(Reset), .Start(startE), .Signed(sgnE),
        .OpA(opAE), .OpB(opBE), .Busy(busyE), .Stall(stallE), .Done(doneE),
        .Product(productE), .ProductLo(productLoE)
    );

    // Reference: true mathematical product truncated to 16 bits.
    function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b, input bit s);
        int pa, pb;
        logic [31:0] full;
        pa = s ? int'($signed(a)) : int'(a);
        pb = s ? int'($signed(b)) : int'(b);
        full = 32'(pa * pb);
        return full[15:0];
    endfunction

    // Reference latency: fixed 8, or the bit length of |B| (min 1) with early exit.
    function automatic int refLatency(input logic [7:0] b, input bit s, input bit ee);
        int mb, len;
        if (!ee) return 8;
        mb = s ? int'($signed(b)) : int'(b);
        if (mb < 0) mb = -mb;
        len = 0;
        while (mb != 0) begin
            len++;
            mb = mb >> 1;
        end
        return (len == 0) ? 1 : len;
    endfunction

    task automatic tick();
        @(posedge Clock); #1;
    endtask

    // Issue one multiply (Start for one cycle) and wait for Done.
    // lat = edges from the accept edge until Done is seen (-1 on timeout).
    task automatic runOp(input bit ee, input logic [7:0] a, input logic [7:0] b, input bit s,
                         output int lat, output logic [15:0] prod, output logic [7:0] prodLo,
                         output int busyCycles);
        int n;
        if (ee) begin startE = 1'b1; opAE = a; opBE = b; sgnE = s; end
        else    begin start  = 1'b1; opA  = a; opB  = b; sgn  = s; end
        tick();
        startE = 1'b0;
        start  = 1'b0;
        n = 0;
        busyCycles = 0;
        while (!(ee ? doneE : done) && n < 30) begin
            if (ee ? busyE : busy) busyCycles++;
            tick();
            n++;
        end
        lat    = (n >= 30) ? -1 : n;
        prod   = ee ? productE : product;
        prodLo = ee ? productLoE : productLo;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        start = 1'b1; opA = 8'd5; opB = 8'd6;
        tick();
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        tests++; if (product !== 16'h0000) begin fails++; $display("FAIL reset_product got=%h exp=0000", product); end
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL reset_stall got=%b exp=1", stall); end
        start = 1'b0;
        Reset = 1'b0;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_no_run got=%b exp=0", busy); end
        $display("[TB] reset: busy=%b done=%b product=%h", busy, done, product);
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [15:0] p;
        logic [7:0] pl;
        runOp(1'b0, 8'd13, 8'd11, 1'b0, lat, p, pl, bc);
        tests++; if (lat !== 8) begin fails++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        tests++; if (bc !== 8) begin fails++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
        tests++; if (p !== 16'h008F) begin fails++; $display("FAIL basic_product got=%h exp=008f", p); end
        tests++; if (pl !== 8'h8F) begin fails++; $display("FAIL basic_productlo got=%h exp=8f", pl); end
        $display("[TB] basic 13*11: product=%h lat=%0d", p, lat);
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        tests++; if (product !== 16'h008F) begin fails++; $display("FAIL basic_product_held got=%h exp=008f", product); end
    endtask

    task automatic test_corners();
        logic [7:0]  va [3] = '{8'hFD, 8'h80, 8'hFF};
        logic [7:0]  vb [3] = '{8'h05, 8'h80, 8'hFF};
        bit          vs [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] ve [3] = '{16'hFFF1, 16'h4000, 16'hFE01};
        int lat, bc;
        logic [15:0] p;
        logic [7:0] pl;
        for (int i = 0; i < 3; i++) begin
            runOp(1'b0, va[i], vb[i], vs[i], lat, p, pl, bc);
            tests++;
            if (p !== ve[i] || lat !== 8) begin
                fails++;
                $display("FAIL corner_%0d got=%h lat=%0d exp=%h lat=8", i, p, lat, ve[i]);
            end
            $display("[TB] corner s=%0d %h*%h: product=%h", vs[i], va[i], vb[i], p);
            tick();
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [15:0] p, e;
        logic [7:0] pl, a, b;
        bit s;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            e = refProduct(a, b, s);
            runOp(1'b0, a, b, s, lat, p, pl, bc);
            tests++;
            if (p !== e || pl !== e[7:0] || lat !== 8) begin
                fails++;
                $display("FAIL random_%0d s=%0d a=%h b=%h got=%h/%h lat=%0d exp=%h lat=8", i, s, a, b, p, pl, lat, e);
            end
            $display("[TB] random s=%0d %h*%h: product=%h", s, a, b, p);
            if ($urandom_range(1, 0) == 1) tick();
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        start = 1'b1; sgn = 1'b0; opA = 8'd2; opB = 8'd3;
        tick();
        n = 0;
        while (!done && n < 30) begin
            tests++;
            if (!busy) begin fails++; $display("FAIL b2b_run1_busy cyc=%0d got=0 exp=1", n); end
            tick();
            n++;
        end
        tests++; if (n !== 8) begin fails++; $display("FAIL b2b_lat1 got=%0d exp=8", n); end
        tests++; if (product !== 16'd6) begin fails++; $display("FAIL b2b_product1 got=%h exp=0006", product); end
        $display("[TB] back_to_back first: product=%h", product);
        opA = 8'd4; opB = 8'd5;
        tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_no_idle got busy=%b exp=1", busy); end
        // Operands change during RUN; Start still high.
        opA = 8'd7; opB = 8'd7;
        tick();
        tests++; if (product !== 16'd6) begin fails++; $display("FAIL b2b_product_held_run got=%h exp=0006", product); end
        n = 1;
        while (!done && n < 30) begin tick(); n++; end
        tests++; if (n !== 8) begin fails++; $display("FAIL b2b_lat2 got=%0d exp=8", n); end
        tests++; if (product !== 16'd20) begin fails++; $display("FAIL b2b_product2 got=%h exp=0014", product); end
        $display("[TB] back_to_back second: product=%h", product);
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_abort();
        bit sawDone;
        start = 1'b1; sgn = 1'b0; opA = 8'd7; opB = 8'd9;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
        tests++; if (product !== 16'h0000) begin fails++; $display("FAIL abort_product got=%h exp=0000", product); end
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) sawDone = 1'b1;
            tick();
        end
        tests++; if (sawDone !== 1'b0) begin fails++; $display("FAIL abort_no_done got=1 exp=0"); end
        $display("[TB] reset_abort: busy=%b product=%h", busy, product);
    endtask

    task automatic test_early_exit();
        int lat, bc, el;
        logic [15:0] p, e;
        logic [7:0] pl, a, b;
        bit s;
        runOp(1'b1, 8'd200, 8'd1, 1'b0, lat, p, pl, bc);
        tests++; if (lat !== 1) begin fails++; $display("FAIL ee_latency got=%0d exp=1", lat); end
        tests++; if (p !== 16'd200) begin fails++; $display("FAIL ee_product got=%h exp=00c8", p); end
        $display("[TB] early_exit 200*1: product=%h lat=%0d", p, lat);
        tick();
        runOp(1'b0, 8'd200, 8'd1, 1'b0, lat, p, pl, bc);
        tests++; if (lat !== 8 || p !== 16'd200) begin fails++; $display("FAIL fixed_200x1 got=%h lat=%0d exp=00c8 lat=8", p, lat); end
        $display("[TB] fixed 200*1: product=%h lat=%0d", p, lat);
        tick();
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom); s = 1'($urandom);
            b = (i < 3) ? 8'(i) : 8'($urandom >> $urandom_range(7, 0));
            e = refProduct(a, b, s);
            el = refLatency(b, s, 1'b1);
            runOp(1'b1, a, b, s, lat, p, pl, bc);
            tests++;
            if (p !== e || lat !== el) begin
                fails++;
                $display("FAIL ee_random_%0d s=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=%0d", i, s, a, b, p, lat, e, el);
            end
            $display("[TB] early_exit s=%0d %h*%h: product=%h lat=%0d", s, a, b, p, lat);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_early_exit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
